// File: rtl/instruction_memory_loadable_if.sv
// instruction_memory_loadable_if: load-stream and fetch-port bundle of the loadable instruction memory.
interface instruction_memory_loadable_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  load_start;
    logic                  load_valid;
    logic                  load_last;
    logic [31:0]           load_data;
    logic                  load_ready;
    logic                  load_done;
    logic                  mem_ready;
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic [31:0]           fetch_instr;
    logic                  fetch_misaligned;
    logic                  fetch_oob;

    modport master (
        output load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
        input  load_ready, load_done, mem_ready, fetch_valid, fetch_instr, fetch_misaligned, fetch_oob
    );
    modport slave (
        input  load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
        output load_ready, load_done, mem_ready, fetch_valid, fetch_instr, fetch_misaligned, fetch_oob
    );
endinterface

// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: cleared-on-reset word memory with streamed program load and registered fetch.
module instruction_memory_loadable #(
    parameter int          WORDS      = 64,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input logic clk,
    input logic reset_n,
    instruction_memory_loadable_if.slave bus
);
    localparam int IW = $clog2(WORDS);
    localparam logic [1:0] CLEAR = 2'd0, IDLE = 2'd1, LOADING = 2'd2, READY = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] clr_ptr, load_ptr, wr_ptr, idx;
    logic [31:0]   mem [WORDS];
    logic          accept_word, load_end, we, accept, mis, oob;

    always_comb begin
        accept_word = state == LOADING && bus.load_valid;
        load_end    = accept_word && (bus.load_last || load_ptr == IW'(WORDS - 1));
        we          = reset_n && (state == CLEAR || accept_word);
        wr_ptr      = state == CLEAR ? clr_ptr : load_ptr;
        accept      = bus.fetch_req && state == READY;
        idx         = bus.fetch_addr[IW+1:2];
        mis         = |bus.fetch_addr[1:0];
        oob         = !mis && |bus.fetch_addr[ADDR_WIDTH-1:IW+2];
    end

    assign bus.load_ready = state == LOADING;
    assign bus.mem_ready  = state == READY;

    always_ff @(posedge clk)
        if (we)
            mem[wr_ptr] <= state == CLEAR ? 32'd0 : bus.load_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                <= CLEAR;
            clr_ptr              <= '0;
            load_ptr             <= '0;
            bus.load_done        <= 1'b0;
            bus.fetch_valid      <= 1'b0;
            bus.fetch_instr      <= '0;
            bus.fetch_misaligned <= 1'b0;
            bus.fetch_oob        <= 1'b0;
        end else begin
            bus.load_done        <= load_end;
            bus.fetch_valid      <= accept;
            bus.fetch_misaligned <= accept && mis;
            bus.fetch_oob        <= accept && oob;
            bus.fetch_instr      <= !accept ? 32'd0 : (mis || oob) ? NOP_INSTR : mem[idx];
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == IW'(WORDS - 1))
                        state <= IDLE;
                end
                IDLE, READY:
                    if (bus.load_start) begin
                        state    <= LOADING;
                        load_ptr <= '0;
                    end
                default:
                    // Writing the last index ends the load so the pointer never wraps onto word 0.
                    if (accept_word) begin
                        load_ptr <= load_ptr + 1'b1;
                        if (load_end)
                            state <= READY;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb_instruction_memory_loadable: directed checks of clear sweep, load FSM, fetch responses and faults.
module tb_instruction_memory_loadable;
    logic clk, reset_n;
    int   total = 0, bad = 0;
    logic seen_ready, seen_mem, seen_valid;
    int   done_cnt;

    instruction_memory_loadable_if bus ();
    instruction_memory_loadable dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " load_ready"}, 32'(bus.load_ready), 0);
        check({tag, " load_done"}, 32'(bus.load_done), 0);
        check({tag, " mem_ready"}, 32'(bus.mem_ready), 0);
        check({tag, " fetch_valid"}, 32'(bus.fetch_valid), 0);
        check({tag, " fetch_instr"}, bus.fetch_instr, 0);
        check({tag, " misaligned"}, 32'(bus.fetch_misaligned), 0);
        check({tag, " oob"}, 32'(bus.fetch_oob), 0);
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        bus.load_valid = 1;
        bus.load_data  = d;
        bus.load_last  = last;
        @(negedge clk);
        bus.load_valid = 0;
        bus.load_last  = 0;
    endtask

    task automatic fetch_chk(input logic [31:0] a, input logic [31:0] exp, input logic em, input logic eo);
        bus.fetch_req  = 1;
        bus.fetch_addr = a;
        @(negedge clk);
        bus.fetch_req = 0;
        check($sformatf("fetch %h valid", a), 32'(bus.fetch_valid), 1);
        check($sformatf("fetch %h instr", a), bus.fetch_instr, exp);
        check($sformatf("fetch %h misaligned", a), 32'(bus.fetch_misaligned), 32'(em));
        check($sformatf("fetch %h oob", a), 32'(bus.fetch_oob), 32'(eo));
    endtask

    initial begin
        reset_n = 0;
        bus.load_start = 0; bus.load_valid = 0; bus.load_last = 0; bus.load_data = 0;
        bus.fetch_req = 0; bus.fetch_addr = 0;
        repeat (2) @(negedge clk);
        check_quiet("reset");

        // Clear sweep with load_start and fetch_req held: both must be ignored.
        reset_n = 1; bus.load_start = 1; bus.fetch_req = 1;
        seen_ready = 0; seen_mem = 0; seen_valid = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            seen_ready |= bus.load_ready;
            seen_mem   |= bus.mem_ready;
            seen_valid |= bus.fetch_valid;
        end
        bus.fetch_req = 0;
        check("clear load_ready", 32'(seen_ready), 0);
        check("clear mem_ready", 32'(seen_mem), 0);
        check("clear fetch_valid", 32'(seen_valid), 0);

        // load_start still high at cycle 64: IDLE now, so LOADING follows.
        @(negedge clk);
        bus.load_start = 0;
        check("idle->loading load_ready", 32'(bus.load_ready), 1);
        check("loading mem_ready", 32'(bus.mem_ready), 0);
        load_word(32'h0050_0093, 0);
        @(negedge clk);
        load_word(32'h0010_8113, 0);
        @(negedge clk);
        load_word(32'h0000_006F, 1);
        check("load3 done", 32'(bus.load_done), 1);
        check("load3 mem_ready", 32'(bus.mem_ready), 1);
        check("load3 load_ready", 32'(bus.load_ready), 0);
        @(negedge clk);
        check("load3 done pulse width", 32'(bus.load_done), 0);
        fetch_chk(32'h8, 32'h0000_006F, 0, 0);

        bus.fetch_req = 1; bus.fetch_addr = 32'h4;
        @(negedge clk);
        check("b2b first valid", 32'(bus.fetch_valid), 1);
        check("b2b first instr", bus.fetch_instr, 32'h0010_8113);
        bus.fetch_addr = 32'h0;
        @(negedge clk);
        bus.fetch_req = 0;
        check("b2b second valid", 32'(bus.fetch_valid), 1);
        check("b2b second instr", bus.fetch_instr, 32'h0050_0093);
        @(negedge clk);
        check("no req valid", 32'(bus.fetch_valid), 0);
        check("no req instr", bus.fetch_instr, 0);
        fetch_chk(32'hC, 32'h0, 0, 0);

        fetch_chk(32'h6, 32'h13, 1, 0);
        fetch_chk(32'h100, 32'h13, 0, 1);
        fetch_chk(32'h101, 32'h13, 1, 0);
        fetch_chk(32'hFC, 32'h0, 0, 0);

        // 70 words without load_last: terminates after index 63.
        bus.load_start = 1;
        @(negedge clk);
        bus.load_start = 0;
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            bus.load_valid = 1;
            bus.load_data  = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            done_cnt += int'(bus.load_done);
            if (i == 63) check("auto-term done", 32'(bus.load_done), 1);
        end
        bus.load_valid = 0;
        check("auto-term done count", 32'(done_cnt), 1);
        check("auto-term mem_ready", 32'(bus.mem_ready), 1);
        fetch_chk(32'hFC, 32'hA000_003F, 0, 0);
        fetch_chk(32'h0, 32'hA000_0000, 0, 0);

        // Load request together with a fetch: fetch sees old contents.
        bus.load_start = 1; bus.fetch_req = 1; bus.fetch_addr = 32'h4;
        @(negedge clk);
        bus.load_start = 0; bus.fetch_req = 0;
        check("overlap valid", 32'(bus.fetch_valid), 1);
        check("overlap instr", bus.fetch_instr, 32'hA000_0001);
        check("overlap mem_ready", 32'(bus.mem_ready), 0);
        check("overlap load_ready", 32'(bus.load_ready), 1);
        load_word(32'hB000_0000, 0);
        load_word(32'hB000_0001, 0);

        reset_n = 0;
        @(negedge clk);
        check_quiet("mid-load reset");
        reset_n = 1;
        repeat (64) @(negedge clk);
        check("reclear mem_ready", 32'(bus.mem_ready), 0);
        bus.fetch_req = 1; bus.fetch_addr = 32'h0;
        @(negedge clk);
        bus.fetch_req = 0;
        check("idle fetch dropped", 32'(bus.fetch_valid), 0);
        bus.load_start = 1;
        @(negedge clk);
        bus.load_start = 0;
        load_word(32'h0, 1);
        check("reload done", 32'(bus.load_done), 1);
        fetch_chk(32'h0, 32'h0, 0, 0);
        fetch_chk(32'h4, 32'h0, 0, 0);
        fetch_chk(32'hFC, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
- Parametrised successor of the core's instruction store: word-organised memory with a streamed program-load port and a registered, handshaked fetch port.
- After reset, a counter-driven sweep clears every word. A load FSM then accepts the program image word by word.
- Fetches are accepted only once loading is complete. Misaligned and out-of-range fetch addresses are flagged instead of aliasing.
- Sits between the fetch stage (PC side) and the boot/program loader.

Parameters:
- WORDS, 64, number of 32-bit words; power of two, >= 4.
- ADDR_WIDTH, 32, width of the byte address on the fetch port.
- NOP_INSTR, 32'h0000_0013, instruction returned on a faulting fetch (RV32I addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE or READY.
- load_valid  in  1  load_data holds a word to write.
- load_last  in  1  qualifies load_valid; marks the final word of the image.
- load_data  in  32  program word.
- load_ready  out  1  high while in LOADING.
- load_done  out  1  one-cycle pulse when LOADING exits to READY.
- mem_ready  out  1  high in READY; the fetch port is usable.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  byte address.
- fetch_valid  out  1  response valid, exactly one cycle after an accepted request.
- fetch_instr  out  32  fetched word.
- fetch_misaligned  out  1  fault: fetch_addr[1:0] != 0.
- fetch_oob  out  1  fault: word index >= WORDS.

Behaviour:
- States: CLEAR, IDLE, LOADING, READY.
- Reset (reset_n=0 at an edge, any state, including mid-load or mid-clear):
  - state goes to CLEAR, clr_ptr=0, load_ptr=0.
  - All outputs are 0: load_ready, load_done, mem_ready, fetch_valid, fetch_instr, fetch_misaligned, fetch_oob.
- CLEAR:
  - Writes 0 to memory[clr_ptr] each cycle and increments clr_ptr.
  - After writing word WORDS-1, goes to IDLE. Clearing takes exactly WORDS cycles after reset release.
  - load_start is ignored during CLEAR.
- IDLE: load_start -> LOADING with load_ptr=0.
- READY: load_start -> LOADING with load_ptr=0. Memory contents are kept until overwritten.
- LOADING:
  - load_ready=1.
  - On load_valid: write memory[load_ptr] <= load_data, then load_ptr++.
  - Exit to READY with a load_done pulse on the cycle after either:
    - an accepted word with load_last=1, or
    - an accepted write to index WORDS-1 (auto-terminate; no wrap, further words are never written).
  - load_valid=0 cycles are stalls with no write.
  - load_start while in LOADING is ignored.
- Fetch acceptance:
  - A fetch is accepted when fetch_req && mem_ready.
  - fetch_req outside READY is dropped: fetch_valid stays 0 the next cycle.
- Fetch response:
  - Latency is 1 cycle, fully pipelined: back-to-back requests give back-to-back responses.
  - Word index = fetch_addr[ADDR_WIDTH-1:2].
  - Fault priority: misaligned is checked first, then oob. Only one flag is ever high.
  - On any fault, fetch_instr=NOP_INSTR.
  - When no request was accepted, the next cycle has fetch_valid=0 and fetch_instr/flags at 0.
- Simultaneous load_start and fetch_req in READY:
  - The fetch is accepted and responds normally with pre-load contents.
  - The state enters LOADING on the same edge; mem_ready drops the next cycle.

Test Plan:
- Reset, then hold idle -> mem_ready=0 for 64 cycles of CLEAR; state IDLE at cycle 64; no load_ready during CLEAR.
- Load 3 words (0x00500093, 0x00108113, 0x0000006F; load_last on the third) with one stall cycle between words -> load_done pulses once, mem_ready=1; fetch 0x8 -> next cycle fetch_valid=1, fetch_instr=0x0000006F.
- Fetch 0x4 then 0x0 on consecutive cycles -> responses 0x00108113 then 0x00500093 on consecutive cycles; fetch 0xC -> 0x00000000 (cleared word).
- Fetch 0x6 -> fetch_misaligned=1, fetch_oob=0, fetch_instr=0x00000013; fetch 0x100 (WORDS=64) -> fetch_oob=1, fetch_instr=0x00000013; fetch 0x101 -> misaligned only.
- Stream 70 words without load_last -> auto-terminate after word 63, load_done pulse, words 64..69 not written; fetch 0xFC returns word 63.
- Assert reset_n=0 after 2 words of a load -> all outputs 0, CLEAR restarts; after 64 cycles fetch_req is dropped in IDLE (no fetch_valid) and word 0 reads 0 after a new load with load_last on a 0 word.
